// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// uart_rx_cfg : configurable UART receiver, majority-vote sampling, holding reg
// Revision    : 1.0
// ============================================================================
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int IDLE_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baudtick,
    input  logic                 rx,
    input  logic                 rx_ready,
    input  logic                 overrun_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 rx_idle
);
    localparam int TW       = $clog2(OVERSAMPLE);
    localparam int BW       = $clog2(DATA_BITS + 1);
    localparam int IDLE_MAX = IDLE_BITS * OVERSAMPLE;
    localparam int IW       = $clog2(IDLE_MAX + 1);

    localparam logic [TW-1:0] TICK_A    = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_B    = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TICK_V    = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BITS_DONE = BW'(DATA_BITS);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic [IW-1:0] IDLE_SAT  = IW'(IDLE_MAX);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_PARITY   = 3'd3;
    localparam logic [2:0] S_STOP     = 3'd4;
    localparam logic [2:0] S_BRK_WAIT = 3'd5;

    logic                 rx_meta;
    logic                 rx_sync;
    logic [2:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic                 samp_a;
    logic                 samp_b;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bit_cnt;
    logic                 par_bit;
    logic                 stop_cnt;
    logic                 stop_err;
    logic                 stop_one;
    logic [IW-1:0]        idle_cnt;

    logic          vote;
    logic          at_vote;
    logic          at_wrap;
    logic          frame_end;
    logic          is_break;
    logic          complete;
    logic          par_exp;
    logic          par_bad;
    logic [BW-1:0] bit_cnt_nxt;

    // Third sample is taken live at the deciding tick rather than stored.
    assign vote        = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
    assign at_vote     = baudtick && (tick_cnt == TICK_V);
    assign at_wrap     = baudtick && (tick_cnt == TICK_LAST);
    assign bit_cnt_nxt = at_vote ? bit_cnt + 1'b1 : bit_cnt;
    assign frame_end   = at_vote && (state == S_STOP) && (stop_cnt == STOP_LAST);
    assign par_exp     = (PARITY == 1) ? ~(^shreg) : (^shreg);
    assign par_bad     = (PARITY != 0) && (par_bit != par_exp);
    assign is_break    = (shreg == '0) && ((PARITY == 0) || !par_bit) && !stop_one && !vote;
    assign complete    = frame_end && !is_break;
    assign rx_idle     = (idle_cnt == IDLE_SAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            state     <= S_IDLE;
            tick_cnt  <= '0;
            samp_a    <= 1'b0;
            samp_b    <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
            stop_cnt  <= 1'b0;
            stop_err  <= 1'b0;
            stop_one  <= 1'b0;
            break_det <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            break_det <= frame_end && is_break;
            if (baudtick) begin
                if (tick_cnt == TICK_A) samp_a <= rx_sync;
                if (tick_cnt == TICK_B) samp_b <= rx_sync;
                if (state != S_IDLE && state != S_BRK_WAIT)
                    tick_cnt <= at_wrap ? '0 : tick_cnt + 1'b1;
                case (state)
                    S_IDLE: begin
                        if (!rx_sync) begin
                            state    <= S_START;
                            tick_cnt <= '0;
                        end
                    end
                    S_START: begin
                        if (at_vote && vote) begin
                            state <= S_IDLE;
                        end else if (at_wrap) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        if (at_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt_nxt;
                        if (at_wrap && (bit_cnt_nxt == BITS_DONE)) begin
                            if (PARITY != 0) begin
                                state <= S_PARITY;
                            end else begin
                                state    <= S_STOP;
                                stop_cnt <= 1'b0;
                                stop_err <= 1'b0;
                                stop_one <= 1'b0;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (at_vote) par_bit <= vote;
                        if (at_wrap) begin
                            state    <= S_STOP;
                            stop_cnt <= 1'b0;
                            stop_err <= 1'b0;
                            stop_one <= 1'b0;
                        end
                    end
                    S_STOP: begin
                        // Leave at mid-bit of the last stop so a back-to-back start edge is seen.
                        if (frame_end) begin
                            state <= is_break ? S_BRK_WAIT : S_IDLE;
                        end else begin
                            if (at_vote) begin
                                stop_err <= stop_err | ~vote;
                                stop_one <= stop_one | vote;
                            end
                            if (at_wrap) stop_cnt <= 1'b1;
                        end
                    end
                    S_BRK_WAIT: begin
                        if (rx_sync) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (complete && (!rx_valid || rx_ready)) begin
                rx_data    <= shreg;
                parity_err <= par_bad;
                frame_err  <= stop_err | ~vote;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (complete && rx_valid && !rx_ready)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (state != S_IDLE) begin
            idle_cnt <= '0;
        end else if (baudtick) begin
            if (!rx_sync)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_SAT)
                idle_cnt <= idle_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_cfg : scoreboard bench for uart_rx_cfg (8 data, even parity, 1 stop)
// Revision       : 1.0
// ============================================================================
module tb_uart_rx_cfg;
    localparam int OS     = 8;
    localparam int DIV    = 4;
    localparam int BITCLK = OS * DIV;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baudtick = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic       overrun_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       break_det;
    logic       rx_idle;

    int   checks = 0;
    int   failures = 0;
    int   brk_seen = 0;
    int   brk_exp = 0;
    bit   rand_ready = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    uart_rx_cfg #(
        .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1), .IDLE_BITS(2)
    ) dut (
        .clk(clk), .reset(reset), .baudtick(baudtick), .rx(rx),
        .rx_ready(rx_ready), .overrun_clr(overrun_clr), .rx_data(rx_data),
        .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .break_det(break_det), .rx_idle(rx_idle)
    );

    always #5 clk = ~clk;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            baudtick = (cnt == DIV - 1);
            cnt = (cnt == DIV - 1) ? 0 : cnt + 1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit exceeded");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Accepted word: valid & ready seen at negedge is taken on the next posedge.
    always @(negedge clk) begin
        if (!reset && rx_valid && rx_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word actual=%0h required=none", rx_data);
            end else begin
                mon_e = sb.pop_front();
                if (rx_data !== mon_e.d || parity_err !== mon_e.pe || frame_err !== mon_e.fe) begin
                    failures++;
                    $display("FAIL word actual=%0h/pe%0b/fe%0b required=%0h/pe%0b/fe%0b",
                             rx_data, parity_err, frame_err, mon_e.d, mon_e.pe, mon_e.fe);
                end
            end
        end
        if (!reset && break_det) brk_seen++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic b, input int nbits);
        rx = b;
        wait_clks(nbits * BITCLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input int gap);
        send_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) send_bits(d[i], 1);
        send_bits(pbit, 1);
        send_bits(sbit, 1);
        if (gap > 0) send_bits(1'b1, gap);
    endtask

    // Reference: a delivered word carries parity_err when the sent bit breaks even parity.
    task automatic push_exp(input logic [7:0] d, input logic pbit, input logic sbit);
        exp_t e;
        e.d  = d;
        e.pe = (pbit != (^d));
        e.fe = ~sbit;
        sb.push_back(e);
    endtask

    task automatic good_frame(input logic [7:0] d);
        push_exp(d, ^d, 1'b1);
        send_frame(d, ^d, 1'b1, 1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            wait_clks(1);
            n++;
        end
        wait_clks(4);
        check(name, sb.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_parity_err"}, parity_err, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_break_det"}, break_det, 0);
        check({tag, "_rx_idle"}, rx_idle, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;
        int         gap;

        wait_clks(3);
        reset = 1'b0;
        check_all_zero("reset");

        wait_clks(2 * OS * DIV + 3 * DIV);
        check("rx_idle_sat", rx_idle, 1);

        // 1: clean frame, idle flag must drop while the frame is on the wire
        push_exp(8'hA5, 1'b0, 1'b1);
        fork
            send_frame(8'hA5, 1'b0, 1'b1, 1);
            begin
                wait_clks(2 * BITCLK);
                check("rx_idle_in_frame", rx_idle, 0);
            end
        join
        drain("t1_drain");

        // 2: glitch shorter than half a bit is a false start
        rx = 1'b0;
        wait_clks(2 * DIV);
        send_bits(1'b1, 2);
        check("t2_no_valid", rx_valid, 0);
        good_frame(8'h3C);
        drain("t2_drain");

        // 3: errored frames are still delivered
        push_exp(8'h01, 1'b0, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1, 1);
        push_exp(8'h55, ^8'h55, 1'b0);
        send_frame(8'h55, ^8'h55, 1'b0, 1);
        drain("t3_drain");

        // 4: second frame dropped while the first is held
        rx_ready = 1'b0;
        push_exp(8'h11, ^8'h11, 1'b1);
        send_frame(8'h11, ^8'h11, 1'b1, 1);
        send_frame(8'h22, ^8'h22, 1'b1, 1);
        check("t4_overrun_set", overrun, 1);
        check("t4_valid_held", rx_valid, 1);
        check("t4_data_held", rx_data, 8'h11);
        overrun_clr = 1'b1;
        wait_clks(1);
        overrun_clr = 1'b0;
        wait_clks(1);
        check("t4_overrun_clr", overrun, 0);
        rx_ready = 1'b1;
        drain("t4_drain");

        // 5: break then recovery
        send_bits(1'b0, 12);
        brk_exp++;
        send_bits(1'b1, 1);
        check("t5_break_count", brk_seen, brk_exp);
        check("t5_no_valid", rx_valid, 0);
        good_frame(8'h7E);
        drain("t5_drain");

        // 6: reset in the middle of a frame
        send_bits(1'b0, 1);
        send_bits(1'b1, 3);
        reset = 1'b1;
        rx = 1'b1;
        wait_clks(2);
        reset = 1'b0;
        check_all_zero("t6_reset");
        wait_clks(10 * BITCLK);
        check("t6_no_valid", rx_valid, 0);
        good_frame(8'h80);
        drain("t6_drain");

        // Randomised frames with random consumer back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            d   = 8'($urandom_range(0, 255));
            p   = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            s   = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            if (d == 8'h00 && !p && !s) s = 1'b1;
            gap = $urandom_range(0, 2);
            if (!s && gap == 0) gap = 1;
            push_exp(d, p, s);
            send_frame(d, p, s, gap);
        end
        send_bits(1'b1, 2);
        drain("rand_drain");
        rand_ready = 1'b0;
        rx_ready = 1'b1;

        check("final_overrun", overrun, 0);
        check("final_break_count", brk_seen, brk_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
